// File: rtl/run_ctrl.sv
// rtl/run_ctrl.sv - program-run controller and fetch sequencer (optional watchdog: RUN_CTRL_WATCHDOG_EN)
module run_ctrl #(
    parameter int D     = 12,
    parameter int NPROG = 3,
    parameter int SW    = 2,
    parameter int CW    = 16,
    parameter int TMO   = 4000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req,
    input  logic [SW-1:0]      prog_sel,
    input  logic [NPROG*D-1:0] start_tbl,
    input  logic               halt,
    input  logic               absjump_en,
    input  logic               reljump_en,
    input  logic [D-1:0]       target,
    input  logic               stall,
    output logic [D-1:0]       prog_ctr,
    output logic               run,
    output logic               busy,
    output logic               done,
    output logic               bad_sel,
    output logic [CW-1:0]      cycles,
    output logic               timeout
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [SW:0] NPROG_W = (SW+1)'(NPROG);

    if (NPROG < 1 || (1 << SW) < NPROG || TMO < 1) begin : g_bad_params
        $error("run_ctrl: inconsistent parameters");
    end

    state_t        state;
    logic [SW-1:0] sel;
    logic [D-1:0]  entry;
    logic          sel_oob;

    assign sel_oob = ({1'b0, prog_sel} >= NPROG_W);

    always_comb begin
        entry = '0;
        for (int i = 0; i < NPROG; i++) begin
            if (sel == SW'(i)) entry = start_tbl[i*D +: D];
        end
    end

`ifdef RUN_CTRL_WATCHDOG_EN
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);
    logic timeout_q;
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            sel      <= '0;
            prog_ctr <= '0;
            run      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bad_sel  <= 1'b0;
            cycles   <= '0;
`ifdef RUN_CTRL_WATCHDOG_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state   <= LOAD;
                        busy    <= 1'b1;
                        sel     <= sel_oob ? '0 : prog_sel;
                        bad_sel <= sel_oob;
                    end
                end
                LOAD: begin
                    prog_ctr <= entry;
                    cycles   <= '0;
                    run      <= 1'b1;
                    state    <= RUN;
`ifdef RUN_CTRL_WATCHDOG_EN
                    timeout_q <= 1'b0;
`endif
                end
                RUN: begin
                    // The halting edge is still a RUN cycle, so it is counted too.
                    if (cycles != '1) cycles <= cycles + 1'b1;
                    if (halt) begin
                        state <= DONE;
                        run   <= 1'b0;
                        done  <= 1'b1;
`ifdef RUN_CTRL_WATCHDOG_EN
                    end else if (cycles == TMO_LAST) begin
                        state     <= DONE;
                        run       <= 1'b0;
                        done      <= 1'b1;
                        timeout_q <= 1'b1;
`endif
                    end else if (stall) begin
                        prog_ctr <= prog_ctr;
                    end else if (absjump_en) begin
                        prog_ctr <= target;
                    end else if (reljump_en) begin
                        prog_ctr <= prog_ctr + target;
                    end else begin
                        prog_ctr <= prog_ctr + 1'b1;
                    end
                end
                DONE: begin
                    // No auto-restart: req must drop before another run is accepted.
                    if (!req) begin
                        state <= IDLE;
                        done  <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// tb/tb_run_ctrl.sv - directed self-checking bench for run_ctrl
module tb_run_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic [1:0]  prog_sel = '0;
    logic [35:0] start_tbl = '0;
    logic        halt = 1'b0;
    logic        absjump_en = 1'b0;
    logic        reljump_en = 1'b0;
    logic [11:0] target = '0;
    logic        stall = 1'b0;
    logic [11:0] prog_ctr;
    logic        run, busy, done, bad_sel, timeout;
    logic [15:0] cycles;

    int checks = 0;
    int errors = 0;

    run_ctrl #(.D(12), .NPROG(3), .SW(2), .CW(16), .TMO(10)) dut (
        .clk(clk), .reset(reset), .req(req), .prog_sel(prog_sel), .start_tbl(start_tbl),
        .halt(halt), .absjump_en(absjump_en), .reljump_en(reljump_en), .target(target),
        .stall(stall), .prog_ctr(prog_ctr), .run(run), .busy(busy), .done(done),
        .bad_sel(bad_sel), .cycles(cycles), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [1:0] s);
        prog_sel = s;
        req = 1'b1;
        step();
        step();
    endtask

    task automatic finish_run();
        halt = 1'b1;
        step();
        halt = 1'b0;
        req = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        checks++; if ({run, busy, done, bad_sel, timeout} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b want 00000", {run, busy, done, bad_sel, timeout}); end
        checks++; if (prog_ctr !== 12'h000) begin errors++; $display("FAIL reset_pc got %h want 000", prog_ctr); end
        checks++; if (cycles !== 16'd0) begin errors++; $display("FAIL reset_cycles got %0d want 0", cycles); end
        @(negedge clk);
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        start_tbl = {12'h200, 12'h100, 12'h000};
        prog_sel = 2'd1;
        req = 1'b1;
        step();
        checks++; if ({busy, run} !== 2'b10) begin errors++; $display("FAIL load_state busy/run got %b want 10", {busy, run}); end
        step();
        checks++; if (run !== 1'b1 || prog_ctr !== 12'h100) begin errors++; $display("FAIL basic_first got run=%b pc=%h want run=1 pc=100", run, prog_ctr); end
        for (int i = 1; i < 5; i++) begin
            step();
            checks++; if (prog_ctr !== 12'h100 + 12'(i)) begin errors++; $display("FAIL basic_seq got %h want %h", prog_ctr, 12'h100 + 12'(i)); end
        end
        halt = 1'b1;
        step();
        halt = 1'b0;
        checks++; if ({done, run, busy} !== 3'b101 || prog_ctr !== 12'h104) begin errors++; $display("FAIL basic_done got d/r/b=%b pc=%h want 101 pc=104", {done, run, busy}, prog_ctr); end
        checks++; if (cycles !== 16'd5) begin errors++; $display("FAIL basic_cycles got %0d want 5", cycles); end
        step();
        checks++; if (done !== 1'b1 || prog_ctr !== 12'h104) begin errors++; $display("FAIL basic_hold got done=%b pc=%h want done=1 pc=104", done, prog_ctr); end
        req = 1'b0;
        step();
        checks++; if ({done, busy} !== 2'b00 || cycles !== 16'd5) begin errors++; $display("FAIL basic_release got d/b=%b cycles=%0d want 00 cycles=5", {done, busy}, cycles); end
    endtask

    task automatic test_reset_mid_run();
        start_tbl = {12'h200, 12'h100, 12'h010};
        start_run(2'd0);
        step();
        step();
        checks++; if (prog_ctr !== 12'h012) begin errors++; $display("FAIL mid_pc got %h want 012", prog_ctr); end
        #2 reset = 1'b0;
        #1;
        checks++; if ({run, busy, done, bad_sel, timeout} !== 5'b0 || prog_ctr !== 12'h000 || cycles !== 16'd0) begin errors++; $display("FAIL mid_reset got flags=%b pc=%h cycles=%0d want 0", {run, busy, done, bad_sel, timeout}, prog_ctr, cycles); end
        req = 1'b0;
        step();
        reset = 1'b1;
        step();
        checks++; if ({run, busy} !== 2'b00) begin errors++; $display("FAIL mid_idle got run/busy=%b want 00", {run, busy}); end
        start_run(2'd0);
        checks++; if (prog_ctr !== 12'h010 || cycles !== 16'd0 || run !== 1'b1) begin errors++; $display("FAIL mid_restart got pc=%h cycles=%0d run=%b want 010 0 1", prog_ctr, cycles, run); end
        finish_run();
    endtask

    task automatic test_jump();
        start_tbl = {12'h200, 12'h010, 12'h000};
        start_run(2'd1);
        absjump_en = 1'b1; reljump_en = 1'b1; target = 12'h080;
        step();
        checks++; if (prog_ctr !== 12'h080) begin errors++; $display("FAIL jump_abs got %h want 080", prog_ctr); end
        absjump_en = 1'b0; target = 12'hFFE;
        step();
        checks++; if (prog_ctr !== 12'h07E) begin errors++; $display("FAIL jump_rel got %h want 07E", prog_ctr); end
        reljump_en = 1'b0; absjump_en = 1'b1; target = 12'h123; halt = 1'b1;
        step();
        absjump_en = 1'b0; halt = 1'b0;
        checks++; if (prog_ctr !== 12'h07E || done !== 1'b1 || cycles !== 16'd3) begin errors++; $display("FAIL jump_halt got pc=%h done=%b cycles=%0d want 07E 1 3", prog_ctr, done, cycles); end
        req = 1'b0;
        step();
    endtask

    task automatic test_wrap_stall();
        start_tbl = {12'hFFE, 12'h100, 12'h000};
        start_run(2'd2);
        step();
        checks++; if (prog_ctr !== 12'hFFF) begin errors++; $display("FAIL wrap_fff got %h want FFF", prog_ctr); end
        step();
        checks++; if (prog_ctr !== 12'h000 || cycles !== 16'd2) begin errors++; $display("FAIL wrap_zero got pc=%h cycles=%0d want 000 2", prog_ctr, cycles); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) step();
        stall = 1'b0;
        checks++; if (prog_ctr !== 12'h000 || cycles !== 16'd5 || run !== 1'b1) begin errors++; $display("FAIL stall_hold got pc=%h cycles=%0d run=%b want 000 5 1", prog_ctr, cycles, run); end
        step();
        checks++; if (prog_ctr !== 12'h001) begin errors++; $display("FAIL stall_resume got %h want 001", prog_ctr); end
        finish_run();
        checks++; if (cycles !== 16'd7) begin errors++; $display("FAIL stall_cycles got %0d want 7", cycles); end
    endtask

    task automatic test_select_req();
        start_tbl = {12'h200, 12'h100, 12'h040};
        start_run(2'd3);
        checks++; if (bad_sel !== 1'b1 || prog_ctr !== 12'h040) begin errors++; $display("FAIL badsel got bad=%b pc=%h want 1 040", bad_sel, prog_ctr); end
        req = 1'b0;
        step();
        step();
        checks++; if (run !== 1'b1 || prog_ctr !== 12'h042) begin errors++; $display("FAIL reqdrop_run got run=%b pc=%h want 1 042", run, prog_ctr); end
        halt = 1'b1;
        step();
        halt = 1'b0;
        checks++; if (done !== 1'b1 || bad_sel !== 1'b1) begin errors++; $display("FAIL reqdrop_done got done=%b bad=%b want 1 1", done, bad_sel); end
        step();
        checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL reqdrop_idle got d/b=%b want 00", {done, busy}); end
        start_run(2'd1);
        checks++; if (bad_sel !== 1'b0 || prog_ctr !== 12'h100) begin errors++; $display("FAIL goodsel got bad=%b pc=%h want 0 100", bad_sel, prog_ctr); end
        finish_run();
    endtask

    task automatic test_watchdog();
        start_tbl = {12'h200, 12'h100, 12'h000};
        start_run(2'd1);
`ifdef RUN_CTRL_WATCHDOG_EN
        for (int i = 0; i < 9; i++) step();
        checks++; if (run !== 1'b1 || cycles !== 16'd9) begin errors++; $display("FAIL wd_pre got run=%b cycles=%0d want 1 9", run, cycles); end
        step();
        checks++; if (done !== 1'b1 || timeout !== 1'b1 || cycles !== 16'd10 || prog_ctr !== 12'h109) begin errors++; $display("FAIL wd_fire got done=%b to=%b cycles=%0d pc=%h want 1 1 10 109", done, timeout, cycles, prog_ctr); end
        req = 1'b0;
        step();
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL wd_hold got %b want 1", timeout); end
        prog_sel = 2'd1; req = 1'b1;
        step();
        step();
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL wd_clear got %b want 0", timeout); end
        finish_run();
`else
        for (int i = 0; i < 20; i++) step();
        checks++; if (run !== 1'b1 || timeout !== 1'b0 || cycles !== 16'd20 || prog_ctr !== 12'h114) begin errors++; $display("FAIL nowd_run got run=%b to=%b cycles=%0d pc=%h want 1 0 20 114", run, timeout, cycles, prog_ctr); end
        finish_run();
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reset_mid_run();
        test_jump();
        test_wrap_stall();
        test_select_req();
        test_watchdog();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Parametrised program-run controller and fetch sequencer for the single-cycle core.
- Replaces the fixed "done at PC==128" scheme with several things:
  - a 4-phase req/done handshake;
  - selectable program entry points;
  - halt-driven completion;
  - relative and absolute jump handling;
  - a cycle counter.
- Sits between the top-level req/done pins and instr_ROM/Control.
- Drives prog_ctr and the core run enable.

Parameters:
- D, 12, program counter width.
- NPROG, 3, number of selectable programs (≥1).
- SW, 2, prog_sel width; must satisfy 2^SW ≥ NPROG.
- CW, 16, cycle counter width.
- TMO, 4000, watchdog limit in cycles; used only with WATCHDOG_EN.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  start request; level, 4-phase handshake.
- prog_sel  in  SW  program index; sampled when req is accepted.
- start_tbl  in  NPROG*D  entry addresses; program i occupies bits [i*D +: D].
- halt  in  1  halt decode from Control; valid in RUN.
- absjump_en  in  1  absolute jump enable.
- reljump_en  in  1  relative jump enable.
- target  in  D  jump target; offset is two's complement for relative jumps.
- stall  in  1  freezes PC advance while in RUN.
- prog_ctr  out  D  current instruction address.
- run  out  1  core enable; high only in RUN.
- busy  out  1  high in LOAD, RUN, DONE.
- done  out  1  completion flag.
- bad_sel  out  1  prog_sel was ≥ NPROG at acceptance.
- cycles  out  CW  RUN cycles for the last or current program; saturating.
- timeout  out  1  run ended by watchdog.

Behaviour:
- Reset (asserted low, async):
  - state=IDLE, prog_ctr=0.
  - run, busy, done, bad_sel, timeout = 0.
  - cycles=0.
- IDLE:
  - prog_ctr holds.
  - req=1 at an edge → LOAD. At the same edge, latch sel=prog_sel.
  - If prog_sel ≥ NPROG: use sel=0 and set bad_sel=1; otherwise bad_sel=0.
- LOAD (1 cycle):
  - prog_ctr ← start_tbl[sel]; cycles ← 0; timeout ← 0; → RUN.
  - First RUN cycle is 2 edges after req is seen: req high before edge N gives run=1 after edge N+1.
- RUN, evaluated each edge in this priority order:
  1. halt=1 → DONE. prog_ctr holds; halt overrides jumps and stall.
  2. stall=1 → prog_ctr holds.
  3. absjump_en=1 → prog_ctr ← target. Absolute wins over relative if both are set.
  4. reljump_en=1 → prog_ctr ← prog_ctr + target, mod 2^D.
  5. Otherwise prog_ctr ← prog_ctr + 1, wrapping 2^D−1 → 0.
- cycles in RUN:
  - +1 on every RUN edge, stalls included, including the halting edge.
  - Saturates at 2^CW−1.
- req in RUN: deassertion is ignored; the program runs to halt.
- DONE:
  - done=1, run=0; prog_ctr and cycles hold.
  - req=0 → IDLE, with done=0 after that edge.
  - While req stays 1, remain in DONE; there is no auto-restart.
- busy=1 in LOAD, RUN and DONE.
- bad_sel and timeout hold until the next acceptance (bad_sel) or LOAD (timeout).
- Reset asserted mid-RUN: immediate return to reset values; a partial run leaves no residue.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro RUN_CTRL_WATCHDOG_EN.
- Defined:
  - In RUN, if the halt condition is absent and cycles == TMO−1 at an edge → DONE with timeout=1.
  - prog_ctr holds; cycles = TMO.
  - halt on that same edge takes priority: timeout=0.
- Undefined: timeout is tied to 0, and TMO is unused.

Test Plan:
1. Reset mid-run: start a run, then pulse reset low while prog_ctr=0x012 → all outputs 0, state IDLE; next req restarts cleanly.
2. Basic run:
   - Setup: start_tbl = {0x200, 0x100, 0x000}, prog_sel=1, req=1; halt on the 5th RUN cycle.
   - Required: prog_ctr sequence 0x100, 0x101, 0x102, 0x103, 0x104, holding at 0x104; done=1; cycles=5.
   - Handshake: done stays high until req=0; done=0 one edge after.
3. Jump priority:
   - prog_ctr=0x010 with absjump_en=1, reljump_en=1, target=0x080 → 0x080.
   - Then reljump_en=1, target=0xFFE (−2) → 0x07E.
   - Then halt=1 together with absjump_en=1 → holds 0x07E, DONE.
4. Wrap and stall:
   - Start at 0xFFE → 0xFFF, then 0x000.
   - stall=1 for 3 cycles → prog_ctr holds; cycles still advances by 3.
5. Select and req edge cases:
   - prog_sel=3 with NPROG=3 → bad_sel=1, run starts at start_tbl[0].
   - req dropped during RUN → run continues; done asserts on halt, then IDLE on the next edge since req=0.
6. Watchdog: with RUN_CTRL_WATCHDOG_EN and TMO=10, no halt → DONE after 10 RUN cycles, timeout=1, cycles=10. Without the macro: still running after 20 cycles, timeout=0.
